// File: rtl/skullfet_tester.sv
`default_nettype none
// ============================================================================
//  Module   : skullfet_tester
//  Purpose  : Self-test sequencer for the SkullFET inverter and NAND cells.
//             Steps the cell inputs through the four two-input vectors, waits
//             a settle time, samples the cell outputs and compares them with
//             the ideal truth table, accumulating error statistics.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE_CYCLES  cycles between driving a vector and sampling it (1..255)
//    CNT_W          width of the sampled-vector counter
//  Ports
//    wb_clk_i    in   system clock
//    wb_rst_i    in   synchronous active-high reset
//    start       in   begin a run (only honoured in IDLE)
//    abort       in   terminate the current run
//    n_passes    in   4-vector passes per run, latched on start; 0 = endless
//    dut_a       out  registered drive to input A of both cells
//    dut_b       out  registered drive to NAND input B
//    inv_y       in   inverter cell output (asynchronous)
//    nand_y      in   NAND cell output (asynchronous)
//    busy        out  run in progress
//    done        out  one-cycle pulse on normal completion
//    pass        out  last completed run had zero errors
//    err_count   out  vectors with any mismatch (saturating)
//    vec_count   out  vectors sampled in the run (saturating)
//    first_fail  out  {B, A, inv_bad, nand_bad} of the first failing sample
//  Compile-time option
//    SKULLFET_TESTER_SYNC_EN  two-flop synchronisers on inv_y/nand_y; the
//                             settle phase is lengthened by two cycles so the
//                             compared value still lies SETTLE_CYCLES past
//                             the drive edge.
// ============================================================================
module skullfet_tester #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       n_passes,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             inv_y,
    input  logic             nand_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [3:0]       first_fail
);

`ifdef SKULLFET_TESTER_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif
    localparam int         SETTLE_LEN  = SETTLE_CYCLES + SYNC_EXTRA;
    // Counter is loaded with LEN-1 and runs down to 0, giving LEN cycles.
    localparam logic [8:0] SETTLE_LOAD = 9'(SETTLE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [1:0]       vec_idx, vec_idx_n;     // {B, A} of the current vector
    logic [7:0]       pass_idx, pass_idx_n;
    logic [7:0]       npass_lat, npass_lat_n;
    logic [8:0]       settle_cnt, settle_cnt_n;
    logic [7:0]       err_n;
    logic [CNT_W-1:0] vcnt_n;
    logic [3:0]       ff_n;
    logic             pass_n;
    logic             a_n, b_n;
    logic             inv_s, nand_s;
    logic             inv_bad, nand_bad;

    // ------------------------------------------------------------------
    // Optional input synchronisers
    // ------------------------------------------------------------------
`ifdef SKULLFET_TESTER_SYNC_EN
    logic [1:0] inv_sync, nand_sync;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            inv_sync  <= 2'b00;
            nand_sync <= 2'b00;
        end else begin
            inv_sync  <= {inv_sync[0], inv_y};
            nand_sync <= {nand_sync[0], nand_y};
        end
    end

    assign inv_s  = inv_sync[1];
    assign nand_s = nand_sync[1];
`else
    assign inv_s  = inv_y;
    assign nand_s = nand_y;
`endif

    // The drive registers hold the vector under test throughout SAMPLE,
    // so they serve directly as the reference for the truth table.
    assign inv_bad  = (inv_s  != ~dut_a);
    assign nand_bad = (nand_s != ~(dut_a & dut_b));

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            vec_idx    <= 2'd0;
            pass_idx   <= 8'd0;
            npass_lat  <= 8'd0;
            settle_cnt <= 9'd0;
            err_count  <= 8'd0;
            vec_count  <= '0;
            first_fail <= 4'd0;
            pass       <= 1'b0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
        end else begin
            state      <= state_n;
            vec_idx    <= vec_idx_n;
            pass_idx   <= pass_idx_n;
            npass_lat  <= npass_lat_n;
            settle_cnt <= settle_cnt_n;
            err_count  <= err_n;
            vec_count  <= vcnt_n;
            first_fail <= ff_n;
            pass       <= pass_n;
            dut_a      <= a_n;
            dut_b      <= b_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        vec_idx_n    = vec_idx;
        pass_idx_n   = pass_idx;
        npass_lat_n  = npass_lat;
        settle_cnt_n = settle_cnt;
        err_n        = err_count;
        vcnt_n       = vec_count;
        ff_n         = first_fail;
        pass_n       = pass;
        a_n          = dut_a;
        b_n          = dut_b;

        case (state)
            S_IDLE: begin
                a_n = 1'b0;
                b_n = 1'b0;
                if (start && !abort) begin
                    state_n     = S_DRIVE;
                    err_n       = 8'd0;
                    vcnt_n      = '0;
                    ff_n        = 4'd0;
                    pass_n      = 1'b0;
                    npass_lat_n = n_passes;
                    vec_idx_n   = 2'd0;
                    pass_idx_n  = 8'd0;
                end
            end

            S_DRIVE: begin
                b_n          = vec_idx[1];
                a_n          = vec_idx[0];
                settle_cnt_n = SETTLE_LOAD;
                state_n      = S_SETTLE;
            end

            S_SETTLE: begin
                if (settle_cnt == 9'd0) begin
                    state_n = S_SAMPLE;
                end else begin
                    settle_cnt_n = settle_cnt - 9'd1;
                end
            end

            S_SAMPLE: begin
                if (inv_bad || nand_bad) begin
                    if (err_count != 8'hFF) begin
                        err_n = err_count + 8'd1;
                    end
                    if (err_count == 8'd0) begin
                        ff_n = {vec_idx, inv_bad, nand_bad};
                    end
                end
                if (vec_count != '1) begin
                    vcnt_n = vec_count + 1'b1;
                end
                if (vec_idx == 2'd3) begin
                    pass_idx_n = pass_idx + 8'd1;
                    vec_idx_n  = 2'd0;
                    // A latched count of 0 never matches, so the run is endless.
                    if ((npass_lat != 8'd0) && (pass_idx_n == npass_lat)) begin
                        state_n = S_DONE;
                        // Presented alongside the done pulse.
                        pass_n  = (err_n == 8'd0);
                    end else begin
                        state_n = S_DRIVE;
                    end
                end else begin
                    vec_idx_n = vec_idx + 2'd1;
                    state_n   = S_DRIVE;
                end
            end

            S_DONE: begin
                a_n     = 1'b0;
                b_n     = 1'b0;
                state_n = S_IDLE;
            end

            default: begin
                a_n     = 1'b0;
                b_n     = 1'b0;
                state_n = S_IDLE;
            end
        endcase

        // Abort leaves the counters as they stand (a final sample is still
        // counted) but never reports completion.
        if (abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
            a_n     = 1'b0;
            b_n     = 1'b0;
            pass_n  = pass;
        end
    end

endmodule
`default_nettype wire
